// File: rtl/tp_sync_sink.sv
// Two-phase dual-rail word sink: per-rail synchronizers, completion
// detection against a phase register, and a valid/ready output register.
module tp_sync_sink #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0][1:0] in,
    output logic                  ack_o,
    output logic [WIDTH-1:0]      dat_o,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic                  err_o,
    output logic [15:0]           cnt_o
);

    logic [SYNC_STAGES-1:0]                  rsync_q;
    logic                                    rst_n_core;
    logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0]  sync_q;
    logic [WIDTH-1:0][1:0]                   rails;

    logic [WIDTH-1:0][1:0] ph_q, ph_d;
    logic [WIDTH-1:0]      dat_q, dat_d;
    logic                  vld_q, vld_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;

    logic [WIDTH-1:0][1:0] diff;
    logic [WIDTH-1:0]      arrived;
    logic [WIDTH-1:0]      illegal;
    logic [WIDTH-1:0]      dat_new;
    logic                  complete;
    logic                  any_ill;
    logic                  capture;

    // Assert asynchronously, release after SYNC_STAGES edges of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsync_q <= '0;
        end else begin
            rsync_q <= {rsync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_core = rsync_q[SYNC_STAGES-1];

    // Rail synchronizers run from the raw reset so they fill while the
    // core reset is still being released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign rails = sync_q[SYNC_STAGES-1];

    always_comb begin
        diff    = rails ^ ph_q;
        arrived = '0;
        illegal = '0;
        dat_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            arrived[i] = diff[i][1] ^ diff[i][0];
            illegal[i] = diff[i][1] & diff[i][0];
            dat_new[i] = diff[i][1];
        end
    end

    assign complete = &arrived;
    assign any_ill  = |illegal;
    assign capture  = complete & en & ~err_q & (~vld_q | rdy_i);

    always_comb begin
        ph_d  = ph_q;
        dat_d = dat_q;
        vld_d = vld_q;
        ack_d = ack_q;
        err_d = err_q | any_ill;
        cnt_d = cnt_q;
        if (capture) begin
            ph_d  = rails;
            dat_d = dat_new;
            vld_d = 1'b1;
            ack_d = ~ack_q;
            cnt_d = cnt_q + 16'd1;
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_core) begin
        if (!rst_n_core) begin
            ph_q  <= '0;
            dat_q <= '0;
            vld_q <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ph_q  <= ph_d;
            dat_q <= dat_d;
            vld_q <= vld_d;
            ack_q <= ack_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign vld_o = vld_q;
    assign err_o = err_q;
    assign cnt_o = cnt_q;

endmodule

// File: tb/tb_tp_sync_sink.sv
// Directed bench for tp_sync_sink: the bench plays the two-phase
// upstream generator and checks outputs on the falling clock edge.
module tb_tp_sync_sink;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [31:0][1:0] rails;
    logic             ack_o;
    logic [31:0]      dat_o;
    logic             vld_o;
    logic             rdy_i;
    logic             err_o;
    logic [15:0]      cnt_o;

    int checks = 0;
    int errors = 0;

    tp_sync_sink #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in    (rails),
        .ack_o (ack_o),
        .dat_o (dat_o),
        .vld_o (vld_o),
        .rdy_i (rdy_i),
        .err_o (err_o),
        .cnt_o (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Toggle the data-selected rail of every bit set in mask.
    task automatic send_m(input logic [31:0] w, input logic [31:0] m);
        for (int i = 0; i < 32; i++) begin
            if (m[i]) rails[i][w[i]] = ~rails[i][w[i]];
        end
    endtask

    task automatic send(input logic [31:0] w);
        send_m(w, 32'hFFFF_FFFF);
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        rails = '0;
        edges(3);
        rst = 1'b1;
        edges(4);
    endtask

    task automatic fib_word(input logic [31:0] w, input logic prev_ack,
                            input string tag);
        int c;
        send(w);
        c = 0;
        while (ack_o === prev_ack && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_ack"}, {31'd0, ack_o}, {31'd0, ~prev_ack});
        chk({tag, "_dat"}, dat_o, w);
    endtask

    initial begin
        rst   = 1'b0;
        en    = 1'b1;
        rdy_i = 1'b1;
        rails = '0;
        edges(3);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_vld", {31'd0, vld_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_cnt", {16'd0, cnt_o}, 32'd0);
        rst = 1'b1;
        edges(4);
        chk("idle_vld", {31'd0, vld_o}, 32'd0);

        // single word, fixed latency
        send(32'h0000_0001);
        edges(2);
        chk("lat_vld2", {31'd0, vld_o}, 32'd0);
        chk("lat_ack2", {31'd0, ack_o}, 32'd0);
        edges(1);
        chk("lat_vld3", {31'd0, vld_o}, 32'd1);
        chk("lat_dat3", dat_o, 32'h0000_0001);
        chk("lat_ack3", {31'd0, ack_o}, 32'd1);
        chk("lat_cnt3", {16'd0, cnt_o}, 32'd1);

        // Fibonacci stream
        do_reset();
        fib_word(32'd1, 1'b0, "fib0");
        fib_word(32'd1, 1'b1, "fib1");
        fib_word(32'd2, 1'b0, "fib2");
        fib_word(32'd3, 1'b1, "fib3");
        fib_word(32'd5, 1'b0, "fib4");
        fib_word(32'd8, 1'b1, "fib5");
        chk("fib_cnt", {16'd0, cnt_o}, 32'd6);
        chk("fib_err", {31'd0, err_o}, 32'd0);

        // backpressure, then simultaneous drain and capture
        @(negedge clk);
        rdy_i = 1'b0;
        send(32'hA5A5_A5A5);
        edges(3);
        chk("bp_vld1", {31'd0, vld_o}, 32'd1);
        chk("bp_dat1", dat_o, 32'hA5A5_A5A5);
        chk("bp_ack1", {31'd0, ack_o}, 32'd1);
        send(32'h1234_5678);
        edges(6);
        chk("bp_hold_dat", dat_o, 32'hA5A5_A5A5);
        chk("bp_hold_ack", {31'd0, ack_o}, 32'd1);
        chk("bp_hold_cnt", {16'd0, cnt_o}, 32'd7);
        rdy_i = 1'b1;
        edges(1);
        chk("bp_swap_vld", {31'd0, vld_o}, 32'd1);
        chk("bp_swap_dat", dat_o, 32'h1234_5678);
        chk("bp_swap_ack", {31'd0, ack_o}, 32'd0);
        chk("bp_swap_cnt", {16'd0, cnt_o}, 32'd8);
        edges(1);
        chk("bp_drain_vld", {31'd0, vld_o}, 32'd0);

        // partial arrival, bit 31 late by twenty cycles
        send_m(32'h0000_FFFF, 32'h7FFF_FFFF);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("part_wait_vld", {31'd0, vld_o}, 32'd0);
        end
        chk("part_err", {31'd0, err_o}, 32'd0);
        send_m(32'h8000_0000, 32'h8000_0000);
        edges(2);
        chk("part_vld2", {31'd0, vld_o}, 32'd0);
        edges(1);
        chk("part_vld3", {31'd0, vld_o}, 32'd1);
        chk("part_dat", dat_o, 32'h8000_FFFF);
        chk("part_cnt", {16'd0, cnt_o}, 32'd9);

        // en=0 holds a complete word pending
        @(negedge clk);
        en = 1'b0;
        send(32'h0F0F_0F0F);
        edges(6);
        chk("en_vld", {31'd0, vld_o}, 32'd0);
        chk("en_ack", {31'd0, ack_o}, 32'd1);
        chk("en_cnt", {16'd0, cnt_o}, 32'd9);
        en = 1'b1;
        edges(1);
        chk("en_cap_vld", {31'd0, vld_o}, 32'd1);
        chk("en_cap_dat", dat_o, 32'h0F0F_0F0F);
        chk("en_cap_ack", {31'd0, ack_o}, 32'd0);
        chk("en_cap_cnt", {16'd0, cnt_o}, 32'd10);

        // illegal bit 5
        rails[5] = ~rails[5];
        edges(2);
        chk("ill_err2", {31'd0, err_o}, 32'd0);
        edges(1);
        chk("ill_err3", {31'd0, err_o}, 32'd1);
        send(32'h0000_0020);
        edges(6);
        chk("ill_ack", {31'd0, ack_o}, 32'd0);
        chk("ill_cnt", {16'd0, cnt_o}, 32'd10);
        chk("ill_err", {31'd0, err_o}, 32'd1);
        rst   = 1'b0;
        rails = '0;
        #1;
        chk("arst_err", {31'd0, err_o}, 32'd0);
        chk("arst_cnt", {16'd0, cnt_o}, 32'd0);
        chk("arst_dat", dat_o, 32'd0);
        chk("arst_vld", {31'd0, vld_o}, 32'd0);

        // first capture after reset release
        edges(3);
        rst = 1'b1;
        send(32'h0000_0005);
        edges(2);
        chk("rel_vld2", {31'd0, vld_o}, 32'd0);
        edges(1);
        chk("rel_vld3", {31'd0, vld_o}, 32'd1);
        chk("rel_dat", dat_o, 32'h0000_0005);
        chk("rel_cnt", {16'd0, cnt_o}, 32'd1);

        // counter wrap: stream one word per cycle
        do_reset();
        for (int n = 1; n <= 65535; n++) begin
            send(n);
            @(negedge clk);
        end
        edges(4);
        chk("wrap_ffff", {16'd0, cnt_o}, 32'h0000_FFFF);
        chk("wrap_last", dat_o, 32'd65535);
        chk("wrap_err", {31'd0, err_o}, 32'd0);
        send(32'h0000_DEAD);
        edges(3);
        chk("wrap_zero", {16'd0, cnt_o}, 32'd0);
        chk("wrap_dat", dat_o, 32'h0000_DEAD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
